// File: rtl/sar_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sar_conv_scheduler
// Brief    : Round-robin channel arbiter and successive-approximation
//            sequencer for a shared SAR ADC front end (mux, T/H, DAC, comp).
// Revision : 1.0  initial release
// ============================================================================
module sar_conv_scheduler #(
    parameter int WIDTH      = 4,
    parameter int NCH        = 4,
    parameter int SAMPLE_CYC = 2
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic                     abort,
    input  logic                     comp,
    output logic [NCH-1:0]           grant,
    output logic [$clog2(NCH)-1:0]   mux_sel,
    output logic                     sample,
    output logic [WIDTH-1:0]         dac_code,
    output logic [WIDTH-1:0]         result,
    output logic [$clog2(NCH)-1:0]   result_ch,
    output logic                     result_valid,
    output logic                     busy
);

    localparam int c_chw = $clog2(NCH);
    localparam int c_bw  = $clog2(WIDTH);
    localparam int c_sw  = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_CONV   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NCH-1:0]      r_grant,     w_grant_nxt;
    logic [c_chw-1:0]    r_mux_sel,   w_mux_sel_nxt;
    logic                r_sample,    w_sample_nxt;
    logic [WIDTH-1:0]    r_dac,       w_dac_nxt;
    logic [WIDTH-1:0]    r_result,    w_result_nxt;
    logic [c_chw-1:0]    r_result_ch, w_result_ch_nxt;
    logic                r_valid,     w_valid_nxt;
    logic                r_busy,      w_busy_nxt;
    logic [c_chw-1:0]    r_ptr,       w_ptr_nxt;
    logic [c_sw-1:0]     r_scnt,      w_scnt_nxt;
    logic [c_bw-1:0]     r_bit,       w_bit_nxt;

    logic                w_found;
    logic [c_chw-1:0]    w_pick;
    logic [c_chw-1:0]    w_cand;
    int                  w_s;
    logic [WIDTH-1:0]    w_code;
    logic [c_bw-1:0]     w_bit_dn;

    // Round-robin search: scan offsets high to low so the nearest channel
    // after the pointer is the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        w_s     = 0;
        for (int i = NCH; i >= 1; i--) begin
            w_s = int'(r_ptr) + i;
            if (w_s >= NCH) begin
                w_s = w_s - NCH;
            end
            w_cand = c_chw'(w_s);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Next-state and next-output logic; every output register is fed here.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = '0;
        w_mux_sel_nxt   = r_mux_sel;
        w_sample_nxt    = r_sample;
        w_dac_nxt       = r_dac;
        w_result_nxt    = r_result;
        w_result_ch_nxt = r_result_ch;
        w_valid_nxt     = 1'b0;
        w_ptr_nxt       = r_ptr;
        w_scnt_nxt      = r_scnt;
        w_bit_nxt       = r_bit;
        w_bit_dn        = r_bit - c_bw'(1);
        w_code          = r_dac;
        w_code[r_bit]   = comp;

        case (r_state)
            S_IDLE: begin
                w_sample_nxt = 1'b0;
                w_dac_nxt    = '0;
                if (w_found) begin
                    w_state_nxt         = S_SAMPLE;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_mux_sel_nxt       = w_pick;
                    w_ptr_nxt           = w_pick;
                    w_scnt_nxt          = c_sw'(SAMPLE_CYC - 1);
                    w_sample_nxt        = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    w_state_nxt  = S_IDLE;
                    w_sample_nxt = 1'b0;
                    w_dac_nxt    = '0;
                end else if (r_scnt == '0) begin
                    w_state_nxt          = S_CONV;
                    w_sample_nxt         = 1'b0;
                    w_dac_nxt            = '0;
                    w_dac_nxt[WIDTH-1]   = 1'b1;
                    w_bit_nxt            = c_bw'(WIDTH - 1);
                end else begin
                    w_scnt_nxt = r_scnt - c_sw'(1);
                end
            end
            S_CONV: begin
                if (abort) begin
                    w_state_nxt  = S_IDLE;
                    w_sample_nxt = 1'b0;
                    w_dac_nxt    = '0;
                end else if (r_bit != '0) begin
                    // Decide the current bit, then trial the next lower one.
                    w_code[w_bit_dn] = 1'b1;
                    w_dac_nxt        = w_code;
                    w_bit_nxt        = w_bit_dn;
                end else begin
                    w_state_nxt     = S_DONE;
                    w_result_nxt    = w_code;
                    w_result_ch_nxt = r_mux_sel;
                    w_valid_nxt     = 1'b1;
                    w_dac_nxt       = '0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_mux_sel   <= '0;
            r_sample    <= 1'b0;
            r_dac       <= '0;
            r_result    <= '0;
            r_result_ch <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr       <= c_chw'(NCH - 1);
            r_scnt      <= '0;
            r_bit       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_mux_sel   <= w_mux_sel_nxt;
            r_sample    <= w_sample_nxt;
            r_dac       <= w_dac_nxt;
            r_result    <= w_result_nxt;
            r_result_ch <= w_result_ch_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_ptr       <= w_ptr_nxt;
            r_scnt      <= w_scnt_nxt;
            r_bit       <= w_bit_nxt;
        end
    end

    assign grant        = r_grant;
    assign mux_sel      = r_mux_sel;
    assign sample       = r_sample;
    assign dac_code     = r_dac;
    assign result       = r_result;
    assign result_ch    = r_result_ch;
    assign result_valid = r_valid;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sar_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_conv_scheduler
// Brief    : Self-checking bench for sar_conv_scheduler: timeline model of
//            each conversion plus directed literal checks and random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_sar_conv_scheduler;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SC = 2;

    logic           clock = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic           abort;
    logic           comp;
    logic [W-1:0]   vin;
    logic [N-1:0]   grant;
    logic [1:0]     mux_sel;
    logic           sample;
    logic [W-1:0]   dac_code;
    logic [W-1:0]   result;
    logic [1:0]     result_ch;
    logic           result_valid;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: a conversion is a timeline measured from its grant cycle.
    bit m_known = 1'b0;
    int m_phase = -1;
    int m_ptr, m_ch, m_vin, m_mux, m_result, m_rch;

    sar_conv_scheduler #(.WIDTH(W), .NCH(N), .SAMPLE_CYC(SC)) dut (
        .clock(clock), .rst(rst), .req(req), .abort(abort), .comp(comp),
        .grant(grant), .mux_sel(mux_sel), .sample(sample), .dac_code(dac_code),
        .result(result), .result_ch(result_ch), .result_valid(result_valid),
        .busy(busy)
    );

    // Ideal comparator against the analog input of the current channel.
    assign comp = (vin >= dac_code);

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input int ptr, input logic [N-1:0] r);
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (ptr + off) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Trial code at SAR step k: bits above the trial bit equal the input.
    function automatic int exp_dac(input int ph, input int v);
        if (ph >= SC && ph < SC + W) begin
            int k, hm;
            k  = ph - SC;
            hm = ((1 << W) - 1) & ~((1 << (W - k)) - 1);
            return (v & hm) | (1 << (W - 1 - k));
        end
        return 0;
    endfunction

    task automatic model_step();
        int p;
        if (!rst) begin
            m_known = 1'b1; m_phase = -1; m_ptr = N - 1;
            m_mux = 0; m_result = 0; m_rch = 0;
        end else if (!m_known) begin
            m_phase = -1;
        end else if (m_phase < 0) begin
            p = pick(m_ptr, req);
            if (p >= 0) begin
                m_phase = 0; m_ch = p; m_mux = p; m_ptr = p; m_vin = int'(vin);
            end
        end else if (abort && m_phase < SC + W) begin
            m_phase = -1;
        end else if (m_phase == SC + W) begin
            m_phase = -1;
        end else begin
            m_phase++;
            if (m_phase == SC + W) begin
                m_result = m_vin; m_rch = m_ch;
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        cyc++;
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (m_known) begin
            chk("grant",        32'(grant),        (m_phase == 0) ? (1 << m_ch) : 0);
            chk("mux_sel",      32'(mux_sel),      m_mux);
            chk("sample",       32'(sample),       (m_phase >= 0 && m_phase < SC) ? 1 : 0);
            chk("dac_code",     32'(dac_code),     exp_dac(m_phase, m_vin));
            chk("result",       32'(result),       m_result);
            chk("result_ch",    32'(result_ch),    m_rch);
            chk("result_valid", 32'(result_valid), (m_phase == SC + W) ? 1 : 0);
            chk("busy",         32'(busy),         (m_phase >= 0) ? 1 : 0);
        end
    end

    // Directed conversion from IDLE with literal expected trial codes.
    task automatic run_conv(input logic [N-1:0] rq, input logic [W-1:0] v,
                            input logic [4*W-1:0] ds, input logic [W-1:0] r, input int ch);
        req = rq; vin = v;
        step();
        chk("d_grant", 32'(grant), 1 << ch);
        chk("d_sample0", 32'(sample), 1);
        req = '0;
        step();
        chk("d_sample1", 32'(sample), 1);
        for (int k = 0; k < W; k++) begin
            step();
            chk("d_dac", 32'(dac_code), 32'(ds[4*W-1-4*k -: 4]));
        end
        step();
        chk("d_valid", 32'(result_valid), 1);
        chk("d_result", 32'(result), 32'(r));
        chk("d_result_ch", 32'(result_ch), ch);
        step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int gcount;
        int gc [4];
        logic [N-1:0] gv [4];
        for (int i = 0; i < 4; i++) begin gc[i] = 0; gv[i] = '0; end

        rst = 1'b0; req = 4'b1111; abort = 1'b0; vin = 4'd0;
        steps(2);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dac", 32'(dac_code), 0);
        rst = 1'b1;
        step();
        chk("first_grant", 32'(grant), 32'b0001);
        chk("first_mux", 32'(mux_sel), 0);
        req = '0;
        steps(7);

        run_conv(4'b0100, 4'd10, {4'd8, 4'd12, 4'd10, 4'd11}, 4'd10, 2);
        run_conv(4'b0001, 4'd15, {4'd8, 4'd12, 4'd14, 4'd15}, 4'd15, 0);
        run_conv(4'b1000, 4'd0,  {4'd8, 4'd4,  4'd2,  4'd1},  4'd0,  3);

        // Round-robin with continuous requests.
        vin = 4'd6; req = 4'b1011; gcount = 0;
        for (int i = 0; i < 40 && gcount < 4; i++) begin
            step();
            if (grant != '0) begin
                gv[gcount] = grant; gc[gcount] = cyc; gcount++;
            end
        end
        req = '0;
        chk("rr_count", gcount, 4);
        chk("rr_g0", 32'(gv[0]), 32'b0001);
        chk("rr_g1", 32'(gv[1]), 32'b0010);
        chk("rr_g2", 32'(gv[2]), 32'b1000);
        chk("rr_g3", 32'(gv[3]), 32'b0001);
        for (int i = 1; i < 4; i++) chk("rr_gap", gc[i] - gc[i-1], 8);
        steps(7);

        // Abort in the second CONV cycle of a ch1 conversion.
        req = 4'b0010; vin = 4'd9;
        step();
        chk("ab_grant", 32'(grant), 32'b0010);
        req = 4'b0011;
        steps(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_valid", 32'(result_valid), 0);
        chk("ab_result", 32'(result), 6);
        chk("ab_dac", 32'(dac_code), 0);
        step();
        chk("ab_next_grant", 32'(grant), 32'b0001);
        req = '0;
        steps(7);

        // Reset in the middle of a conversion restores the pointer.
        req = 4'b0010; vin = 4'd5;
        step();
        chk("mr_grant", 32'(grant), 32'b0010);
        req = '0;
        steps(2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mr_zero", {grant, 2'(mux_sel), 1'(sample), dac_code, result,
                        2'(result_ch), 1'(result_valid), 1'(busy)}, 0);
        req = 4'b1010;
        step();
        chk("mr_ptr_grant", 32'(grant), 32'b0010);
        req = '0;
        steps(7);
        req = 4'b1000;
        step();
        chk("mr_ch3_grant", 32'(grant), 32'b1000);
        req = '0;
        steps(7);

        // Random traffic with occasional aborts and resets.
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 199) != 0);
            abort = ($urandom_range(0, 24) == 0);
            req   = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
            if (m_phase < 0) vin = W'($urandom_range(0, (1 << W) - 1));
            step();
        end
        rst = 1'b1; abort = 1'b0; req = '0;
        steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sar_conv_scheduler.md
Name: sar_conv_scheduler

Overview:
Multi-channel conversion controller for the shared SAR ADC front end: one analog mux, track/hold, DAC and comparator serve NCH requesters. The block arbitrates channel requests round-robin and drives the mux select and sample pulse. It then runs the successive-approximation bit sequence on the DAC against the comparator and returns a tagged result. It sits between the per-channel acquisition logic and the analog SAR core.

Parameters:
WIDTH, 4, conversion resolution in bits (>=2)
NCH, 4, number of requesting channels (>=2)
SAMPLE_CYC, 2, track/hold acquisition cycles (>=1)

Ports:
clock  input  1  single clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
req  input  NCH  per-channel conversion request, level, held until granted
abort  input  1  cancel conversion in progress
comp  input  1  comparator: 1 = vin >= dac_code
grant  output  NCH  one-hot, 1-cycle pulse when a channel is accepted
mux_sel  output  clog2(NCH)  analog mux channel select
sample  output  1  track/hold control, 1 = track
dac_code  output  WIDTH  DAC trial code
result  output  WIDTH  final conversion code
result_ch  output  clog2(NCH)  channel of result
result_valid  output  1  1-cycle pulse, result/result_ch valid
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE. grant, mux_sel, sample, dac_code, result, result_ch, result_valid and busy all 0. RR pointer=NCH-1, so channel 0 has first priority. Reset overrides abort and every state.
- All outputs are registered.
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE: dac_code=0, sample=0.
  - If req!=0, pick the first set bit searching from pointer+1, wrapping mod NCH.
  - Next cycle: state=SAMPLE, grant one-hot for that channel for that single cycle, mux_sel=channel, pointer=channel, sample counter loaded.
  - If req==0, stay in IDLE.
- SAMPLE: sample=1 for exactly SAMPLE_CYC cycles, then CONV. On entry to CONV: dac_code=1<<(WIDTH-1), bit index=WIDTH-1.
- CONV: lasts exactly WIDTH cycles. dac_code is stable for the whole cycle and comp is sampled at the closing edge.
  - comp=1 keeps the trial bit; comp=0 clears it.
  - If the bit index is >0, the next lower bit is set and the index decrements.
  - After bit 0 is decided: result=final code, result_ch=mux_sel, state=DONE.
- DONE: result_valid=1 for one cycle, then IDLE. result and result_ch hold until the next DONE.
- mux_sel holds from the grant through DONE and IDLE until the next grant.
- Latency: grant in cycle G; result_valid in cycle G+SAMPLE_CYC+WIDTH. Back-to-back throughput is one conversion per SAMPLE_CYC+WIDTH+2 cycles, because one IDLE cycle is always spent before the next grant.
- Requesters must drop req after seeing grant. A req still high is treated as a new request and competes normally under round-robin.
- req changes outside IDLE are ignored. Arbitration happens only in IDLE.
- abort=1 in SAMPLE or CONV: next state IDLE, sample=0, dac_code=0, no result_valid, result unchanged. The pointer stays advanced, so the aborted channel loses its turn. abort in IDLE or DONE is ignored.
- busy=1 in SAMPLE, CONV and DONE.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=4'b1111 -> all outputs 0, no grant. Release rst -> grant=4'b0001 next cycle, mux_sel=0.
- Single conversion, ch2, comp modelled as (10 >= dac_code):
  - Stimulus: req=4'b0100.
  - Required: grant=4'b0100 in cycle G, sample=1 in G..G+1.
  - dac_code sequence 8, 12, 10, 11 in G+2..G+5.
  - result_valid in G+6 with result=10, result_ch=2.
- Round-robin fairness: req=4'b1011 held continuously -> grants in order ch0, ch1, ch3, ch0, with exactly 8 cycles between consecutive grants.
- Extremes: vin=15 gives all comp=1 -> result=15. vin=0 gives all comp=0 -> result=0, dac_code 8, 4, 2, 1.
- Abort: abort=1 during the 2nd CONV cycle of a ch1 conversion -> IDLE next cycle, no result_valid, result keeps its previous value. With req=4'b0011 pending, the next grant goes to ch0.
- Mid-conversion reset: rst=0 during CONV -> next cycle all outputs 0, pointer=NCH-1. A subsequent req=4'b1000 is granted normally.
